// File: rtl/iiitb_lifo_param.sv
// Parametrised LIFO stack with separate push/pop strobes, replace-top, peek of
// the top entry, occupancy count, almost-full threshold and sticky error flags.
module iiitb_lifo_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_LVL = DEPTH - 2,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             Push,
    input  logic             Pop,
    input  logic             ErrClr,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] Top,
    output logic [CW-1:0]    Count,
    output logic             EMPTY,
    output logic             FULL,
    output logic             ALMOST_FULL,
    output logic             OVF,
    output logic             UDF
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_PASS,
        OP_OVF,
        OP_UDF
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];

    op_e              op;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_entry;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] dout_d;
    logic             ovf_d;
    logic             udf_d;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    // Occupancy decodes; valid in the same cycle Count changes
    assign EMPTY       = (Count == '0);
    assign FULL        = (Count == CW'(DEPTH));
    assign ALMOST_FULL = (Count >= CW'(AFULL_LVL));

    // Stack pointer equals Count, so the top entry lives one below it
    assign top_idx   = AW'(Count - CW'(1));
    assign top_entry = mem[top_idx];
    assign Top       = EMPTY ? '0 : top_entry;

    // Classify this cycle's request against the current occupancy
    always_comb begin
        op = OP_IDLE;
        if (EN) begin
            unique case ({Push, Pop})
                2'b10:   op = FULL  ? OP_OVF  : OP_PUSH;
                2'b01:   op = EMPTY ? OP_UDF  : OP_POP;
                2'b11:   op = EMPTY ? OP_PASS : OP_REPL;
                default: op = OP_IDLE;
            endcase
        end
    end

    // Next-state for count, pop data and the memory write port
    always_comb begin
        count_d = Count;
        dout_d  = dataOut;
        wr_en   = 1'b0;
        wr_idx  = AW'(Count);
        unique case (op)
            OP_PUSH: begin
                count_d = Count + CW'(1);
                wr_en   = 1'b1;
            end
            OP_POP: begin
                count_d = Count - CW'(1);
                dout_d  = top_entry;
            end
            OP_REPL: begin
                dout_d = top_entry;
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            OP_PASS: begin
                dout_d = dataIn;
            end
            default: begin
            end
        endcase
    end

    // A new error event in the clearing cycle leaves the flag set
    assign ovf_d = (op == OP_OVF) | (OVF & ~ErrClr);
    assign udf_d = (op == OP_UDF) | (UDF & ~ErrClr);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Count   <= '0;
            dataOut <= '0;
            OVF     <= 1'b0;
            UDF     <= 1'b0;
        end else begin
            Count   <= count_d;
            dataOut <= dout_d;
            OVF     <= ovf_d;
            UDF     <= udf_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_idx] <= dataIn;
        end
    end

endmodule
